// File: rtl/dmem_dump_streamer_if.sv
// Memory read port and (addr,data) record stream between the dump engine, data memory and sink.
// master = dump engine side, slave = memory/sink side.
interface dmem_dump_streamer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output mem_rd_en, mem_rd_addr, out_valid, out_addr, out_data,
    input  mem_rd_data, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, out_valid, out_addr, out_data,
    output mem_rd_data, out_ready
  );
endinterface

// File: rtl/dmem_dump_streamer.sv
// Post-halt data-memory dump engine: walks DEPTH_WORDS words and streams one (addr,data) record each.
// Optional build macro SKIP_ZERO_EN: words reading as zero are dropped instead of emitted.
module dmem_dump_streamer #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                DEPTH_WORDS = 1024,
  parameter int                ADDR_STEP   = 4,
  parameter int                RD_LAT      = 1,
  parameter int                CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic                 halt_f,
  dmem_dump_streamer_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     rec_count
);

  localparam int                IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int                LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH_WORDS - 1);
  localparam logic [LAT_W-1:0]  LAST_LAT = LAT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [IDX_W-1:0]  idx;
  logic [LAT_W-1:0]  lat_cnt;
  logic              lat_hit, last_word, handshake, skip_word, advance;

  assign lat_hit   = (state == WAIT) && (lat_cnt == LAST_LAT);
  assign last_word = (idx == LAST_IDX);
  assign handshake = clk_en && (state == SEND) && bus.out_ready;
`ifdef SKIP_ZERO_EN
  assign skip_word = lat_hit && (bus.mem_rd_data == '0);
`else
  assign skip_word = 1'b0;
`endif
  // A word retires either by being accepted or by being skipped.
  assign advance   = handshake || (clk_en && skip_word);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else if (clk_en) state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred on untaken branches.
    state_nxt       = state;
    busy            = 1'b0;
    done            = 1'b0;
    bus.mem_rd_en   = 1'b0;
    bus.mem_rd_addr = '0;
    bus.out_valid   = 1'b0;
    unique case (state)
      IDLE: if (halt_f) state_nxt = REQ;
      REQ: begin
        busy            = 1'b1;
        bus.mem_rd_en   = 1'b1;
        bus.mem_rd_addr = cur_addr;
        state_nxt       = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (lat_hit) begin
          if (!skip_word)     state_nxt = SEND;
          else if (last_word) state_nxt = DONE;
          else                state_nxt = REQ;
        end
      end
      SEND: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = last_word ? DONE : REQ;
      end
      DONE:    done = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: walk pointer, latency counter, record buffer and saturating record counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr     <= '0;
      idx          <= '0;
      lat_cnt      <= '0;
      bus.out_addr <= '0;
      bus.out_data <= '0;
      rec_count    <= '0;
    end else if (clk_en) begin
      unique case (state)
        IDLE: if (halt_f) begin
          cur_addr <= BASE_ADDR;
          idx      <= '0;
        end
        REQ: lat_cnt <= '0;
        WAIT: begin
          if (!lat_hit) lat_cnt <= lat_cnt + 1'b1;
          else if (!skip_word) begin
            bus.out_addr <= cur_addr;
            bus.out_data <= bus.mem_rd_data;
          end
        end
        SEND: if (bus.out_ready && (rec_count != '1)) rec_count <= rec_count + 1'b1;
        default: ;
      endcase
      if (advance && !last_word) begin
        cur_addr <= cur_addr + STEP;
        idx      <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_dump_streamer.sv
// Bench for dmem_dump_streamer: a table-driven directed dump, hand-written stall/pulse/reset
// sequences, and randomized dumps with stalls and clock-enable gaps checked against a record-list model.
module tb_dmem_dump_streamer;
  localparam int          RD_LAT_A = 2;
  localparam int          RD_LAT_B = 3;
  localparam int          DEPTH_A  = 4;
  localparam int          DEPTH_B  = 10;
  localparam int          CNT_W_B  = 3;
  localparam logic [31:0] BASE_A   = 32'h0000_0500;
  localparam logic [31:0] BASE_B   = 32'hFFFF_FFF0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  logic rst;
  logic clk_en_a, halt_a, ready_a, busy_a, done_a;
  logic clk_en_b, halt_b, ready_b, busy_b, done_b;
  logic [15:0]        cnt_a;
  logic [CNT_W_B-1:0] cnt_b;

  always #5 clk = ~clk;

  dmem_dump_streamer_if #(.ADDR_W(32), .DATA_W(32)) bus_a ();
  dmem_dump_streamer_if #(.ADDR_W(32), .DATA_W(32)) bus_b ();

  dmem_dump_streamer #(
    .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE_A), .DEPTH_WORDS(DEPTH_A),
    .ADDR_STEP(4), .RD_LAT(RD_LAT_A), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .clk_en(clk_en_a), .halt_f(halt_a), .bus(bus_a.master),
    .busy(busy_a), .done(done_a), .rec_count(cnt_a)
  );

  dmem_dump_streamer #(
    .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE_B), .DEPTH_WORDS(DEPTH_B),
    .ADDR_STEP(4), .RD_LAT(RD_LAT_B), .CNT_W(CNT_W_B)
  ) dut_b (
    .clk(clk), .rst(rst), .clk_en(clk_en_b), .halt_f(halt_b), .bus(bus_b.master),
    .busy(busy_b), .done(done_b), .rec_count(cnt_b)
  );

  // Memories with a fixed read latency counted in enabled clock cycles.
  logic [31:0] mem_a  [DEPTH_A];
  logic [31:0] mem_b  [DEPTH_B];
  logic [31:0] pipe_a [RD_LAT_A];
  logic [31:0] pipe_b [RD_LAT_B];

  function automatic int word_idx(input logic [31:0] addr, input logic [31:0] base, input int depth);
    logic [31:0] d;
    d = (addr - base) >> 2;
    return int'(d % 32'(depth));
  endfunction

  always @(posedge clk) begin
    if (clk_en_a) begin
      if (bus_a.mem_rd_en) pipe_a[0] <= mem_a[word_idx(bus_a.mem_rd_addr, BASE_A, DEPTH_A)];
      for (int i = 1; i < RD_LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
    end
    if (clk_en_b) begin
      if (bus_b.mem_rd_en) pipe_b[0] <= mem_b[word_idx(bus_b.mem_rd_addr, BASE_B, DEPTH_B)];
      for (int i = 1; i < RD_LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
    end
  end

  assign bus_a.mem_rd_data = pipe_a[RD_LAT_A-1];
  assign bus_b.mem_rd_data = pipe_b[RD_LAT_B-1];
  assign bus_a.out_ready   = ready_a;
  assign bus_b.out_ready   = ready_b;

  // Monitors sample on the falling edge; inputs only change just after the rising edge.
  rec_t got_a[$];
  rec_t got_b[$];
  int   rd_a = 0, rd_b = 0, vld_a = 0, unstable_b = 0;
  logic held_b = 1'b0;
  rec_t held_rec_b;

  always @(negedge clk) begin
    if (!rst) begin
      if (clk_en_a && bus_a.mem_rd_en) rd_a++;
      if (bus_a.out_valid) vld_a++;
      if (clk_en_a && bus_a.out_valid && ready_a) got_a.push_back('{bus_a.out_addr, bus_a.out_data});
      if (clk_en_b && bus_b.mem_rd_en) rd_b++;
      if (clk_en_b && bus_b.out_valid && ready_b) got_b.push_back('{bus_b.out_addr, bus_b.out_data});
      if (held_b && (!bus_b.out_valid || bus_b.out_addr !== held_rec_b.addr ||
                     bus_b.out_data !== held_rec_b.data)) unstable_b++;
      held_b     = bus_b.out_valid && !(clk_en_b && ready_b);
      held_rec_b = '{bus_b.out_addr, bus_b.out_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cmp_recs(input string tag, input rec_t got[$], input rec_t exp[$]);
    check({tag, "_nrec"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(got[i].addr), 64'(exp[i].addr));
      check($sformatf("%s_data%0d", tag, i), 64'(got[i].data), 64'(exp[i].data));
    end
  endtask

  task automatic wait_done_a(input string tag, input int limit, output int n);
    n = 0;
    while (!done_a && n < limit) begin
      tick();
      n++;
    end
    check({tag, "_done_reached"}, 64'(done_a), 64'd1);
  endtask

  task automatic reset_a();
    rst = 1'b1; halt_a = 1'b0; ready_a = 1'b1; clk_en_a = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    got_a.delete();
    rd_a = 0;
    vld_a = 0;
  endtask

  rec_t vec[DEPTH_A];
  rec_t exp_a[$];
  rec_t exp_b[$];

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, exp_cyc, rd_snap, found, sat;
    rec_t r;

    rst = 1'b1;
    halt_a = 1'b0; ready_a = 1'b1; clk_en_a = 1'b1;
    halt_b = 1'b0; ready_b = 1'b1; clk_en_b = 1'b1;

    // Reset held for three clocks: everything idle and zero.
    repeat (3) tick();
    check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("rst_mem_rd_en", 64'(bus_a.mem_rd_en), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_rec_count", 64'(cnt_a), 64'd0);
    check("rst_addr_data", {bus_a.out_addr, bus_a.out_data}, 64'd0);

    // Directed record table.
    vec[0] = '{32'h500, 32'h0000_0037};
    vec[1] = '{32'h504, 32'h0000_0000};
    vec[2] = '{32'h508, 32'h0000_0012};
    vec[3] = '{32'h50C, 32'hFFFF_FFFF};
    exp_cyc = 1;
    for (int i = 0; i < DEPTH_A; i++) begin
      mem_a[i] = vec[i].data;
`ifdef SKIP_ZERO_EN
      if (vec[i].data == 32'd0) begin
        exp_cyc += RD_LAT_A + 1;
        continue;
      end
`endif
      exp_cyc += RD_LAT_A + 2;
      exp_a.push_back(vec[i]);
    end

    // Full dump with the sink always ready.
    reset_a();
    halt_a = 1'b1;
    wait_done_a("basic", 200, n);
    check("basic_cycles", 64'(n), 64'(exp_cyc));
    cmp_recs("basic", got_a, exp_a);
    check("basic_rec_count", 64'(cnt_a), 64'(exp_a.size()));
    check("basic_reads", 64'(rd_a), 64'(DEPTH_A));
    check("basic_busy_after", 64'(busy_a), 64'd0);

    // Sink stalls five cycles on the second record.
    reset_a();
    halt_a = 1'b1;
    n = 0;
    while (!(bus_a.out_valid && bus_a.out_addr == exp_a[1].addr) && n < 100) begin
      tick();
      n++;
    end
    check("stall_reached", 64'(bus_a.out_valid && bus_a.out_addr == exp_a[1].addr), 64'd1);
    ready_a = 1'b0;
    rd_snap = rd_a;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("stall_valid_rden%0d", k), {bus_a.out_valid, bus_a.mem_rd_en}, 64'b10);
      check($sformatf("stall_addr_data%0d", k), {bus_a.out_addr, bus_a.out_data},
            {exp_a[1].addr, exp_a[1].data});
    end
    check("stall_no_reads", 64'(rd_a), 64'(rd_snap));
    ready_a = 1'b1;
    wait_done_a("stall", 200, n);
    cmp_recs("stall", got_a, exp_a);
    check("stall_rec_count", 64'(cnt_a), 64'(exp_a.size()));

    // One-cycle halt pulse, then halt reasserted after done.
    reset_a();
    halt_a = 1'b1;
    tick();
    halt_a = 1'b0;
    wait_done_a("pulse", 200, n);
    cmp_recs("pulse", got_a, exp_a);
    rd_a = 0;
    vld_a = 0;
    halt_a = 1'b1;
    repeat (10) tick();
    check("rehalt_no_reads", 64'(rd_a), 64'd0);
    check("rehalt_no_valid", 64'(vld_a), 64'd0);
    check("rehalt_done_sticky", 64'(done_a), 64'd1);
    check("rehalt_rec_count", 64'(cnt_a), 64'(exp_a.size()));

    // Reset right after the second record is accepted, then restart.
    reset_a();
    halt_a = 1'b1;
    n = 0;
    while (got_a.size() < 2 && n < 100) begin
      tick();
      n++;
    end
    check("midrst_two_accepted", 64'(got_a.size()), 64'd2);
    rst = 1'b1;
    #1;
    check("midrst_ctrl_zero", {bus_a.out_valid, bus_a.mem_rd_en, busy_a, done_a, cnt_a}, 64'd0);
    check("midrst_addr_data_zero", {bus_a.out_addr, bus_a.out_data}, 64'd0);
    tick();
    rst = 1'b0;
    got_a.delete();
    halt_a = 1'b1;
    tick();
    check("restart_rd", {bus_a.mem_rd_en, bus_a.mem_rd_addr}, {1'b1, BASE_A});
    clk_en_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("freeze_req%0d", k), {bus_a.mem_rd_en, busy_a, bus_a.mem_rd_addr},
            {2'b11, BASE_A});
    end
    clk_en_a = 1'b1;
    wait_done_a("restart", 200, n);
    cmp_recs("restart", got_a, exp_a);
    check("restart_rec_count", 64'(cnt_a), 64'(exp_a.size()));

    // Randomized dumps: wrapping addresses, zeros, stalls, clock-enable gaps, saturating count.
    for (int it = 0; it < 8; it++) begin
      rst = 1'b1; halt_b = 1'b0; clk_en_b = 1'b1; ready_b = 1'b0;
      tick();
      rst = 1'b0;
      exp_b.delete();
      for (int i = 0; i < DEPTH_B; i++) begin
        mem_b[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
        r = '{BASE_B + 32'(4 * i), mem_b[i]};
`ifdef SKIP_ZERO_EN
        if (r.data == 32'd0) continue;
`endif
        exp_b.push_back(r);
      end
      got_b.delete();
      rd_b = 0;
      unstable_b = 0;
      halt_b = 1'b1;
      tick();
      n = 0;
      while (!done_b && n < 3000) begin
        halt_b   = 1'($urandom_range(0, 1));
        clk_en_b = ($urandom_range(0, 3) != 0);
        ready_b  = ($urandom_range(0, 2) != 0);
        tick();
        n++;
      end
      clk_en_b = 1'b1;
      found = 32'(done_b);
      check($sformatf("rnd%0d_done_reached", it), 64'(found), 64'd1);
      cmp_recs($sformatf("rnd%0d", it), got_b, exp_b);
      sat = (exp_b.size() > 7) ? 7 : exp_b.size();
      check($sformatf("rnd%0d_rec_count", it), 64'(cnt_b), 64'(sat));
      check($sformatf("rnd%0d_reads", it), 64'(rd_b), 64'(DEPTH_B));
      check($sformatf("rnd%0d_hold_stable", it), 64'(unstable_b), 64'd0);
      check($sformatf("rnd%0d_busy_after", it), 64'(busy_b), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
